regfile_hazard_ctrl: RTL
========================

Name: regfile_hazard_ctrl

Overview:
- Sequences the 2R/1W register file in the 5-stage RV32I pipeline.
- Tracks the destination registers of in-flight instructions (EX, MEM, WB) in an internal scoreboard.
- Produces load-use stalls, bubbles and forwarding selects.
- Generates the single register-file write strobe/address once per retiring instruction, including under memory back-pressure.

Parameters:
- AW, 5, register address width (32 architectural registers, x0 hard-zero).
- CNT_W, 16, width of saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset
- id_valid  in  1  instruction present in ID
- id_rs1, id_rs2  in  AW  ID source register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  AW  ID destination
- id_wen  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- flush  in  1  branch/jump taken, resolved in EX
- mem_ready  in  1  data memory accepted/returned this cycle; 0 freezes pipeline
- stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX on next edge
- freeze  out  1  hold all pipeline registers (=!mem_ready)
- fwd_a, fwd_b  out  2  operand select for the instruction in EX (registered)
- byp_a, byp_b  out  1  ID operand takes WB write data instead of RF read (combinational)
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- stall_cnt  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Tracking entries EX, MEM, WB: {v, rd, wen, ld}. WB also has a done flag. Reset (async, rst=0): all v=0, done=0, fwd_a/b=00, stall_cnt=0. All outputs are 0 during reset.
- Match(stage, rs) = stage.v & stage.wen & stage.rd==rs & rs!=0 & use_rs. x0 never matches, never stalls, never forwards.
- load_use = id_valid & (Match(EX,rs1) | Match(EX,rs2)) & EX.ld & !flush.
- stall_id = load_use | !mem_ready.
- bubble_ex = (load_use | flush) & mem_ready.
- freeze = !mem_ready.
- Advance edge (mem_ready=1):
  - WB<=MEM and WB.done<=0.
  - MEM<=EX.
  - EX<=ID fields when id_valid & !load_use & !flush; otherwise EX.v<=0.
- Freeze edge (mem_ready=0): EX, MEM and WB hold. flush is ignored while frozen; the pipeline holds flush asserted until mem_ready=1.
- flush and load_use in the same cycle: flush wins. No stall, EX bubble, stall_cnt not incremented.
- Forward select, computed from ID and registered into fwd_a/fwd_b on advance edges. Held on freeze edges; 00 when EX gets a bubble. Priority is newest first:
  - 01 = EX/MEM ALU result: producer was in EX, not a load.
  - 10 = MEM/WB result: producer was in MEM.
  - 00 = register file.
- byp_a/byp_b = Match(WB, rs) & rf_we. This covers the same-cycle write/read hazard, because the RF writes on the edge and reads combinationally.
- rf_we = WB.v & WB.wen & WB.rd!=0 & !WB.done. rf_waddr = WB.rd.
- WB.done<=1 on a freeze edge when rf_we=1. A frozen WB instruction therefore writes exactly once.
- Latency: load-use dependency costs exactly 1 stall cycle. The consumer then sees fwd=10 in EX.
- stall_cnt increments on each advance edge where load_use=1 and saturates at all-ones.
- Reset mid-operation: all tracking is cleared immediately, with no RF write pending.

Decomposition:
- Package regfile_hazard_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - the stage_entry struct {v, rd, wen, ld}
  - the AW default.
- One natural sub-module is hazard_match: the combinational Match for one stage/operand, instantiated 6×.

Test Plan:
- Reset: rst low mid-stream with WB.v=1 -> rf_we=0, fwd=00, stall_cnt=0 immediately.
- ALU chain: `add x5` then `add x6,x5,x5` back-to-back -> consumer fwd_a=fwd_b=01 in EX, no stall.
- Load-use: `lw x7` then `add x8,x7,x0` -> one cycle stall_id=1 and bubble_ex=1, then fwd_a=10, fwd_b=00, stall_cnt=1.
- x0 and WB bypass:
  - `lw x0` then `add x1,x0,x0` -> no stall, fwd=00.
  - Producer three slots ahead writing x9 -> byp_a=1 in ID.
- Back-pressure: mem_ready=0 for 4 cycles with WB writing x3 -> rf_we=1 for exactly 1 cycle, tracking held, freeze=1, stall_id=1 throughout.
- Flush vs load-use: flush=1 with load-use pending -> bubble_ex=1, stall_id=0, stall_cnt unchanged. Also drive 2^CNT_W+3 stalls -> stall_cnt saturates at all-ones.

Source files
------------

// File: rtl/regfile_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_hazard_pkg
// Brief    : Shared encodings, stage tracking entry and helpers for hazard ctrl
// Revision : 1.0 - initial release
// ============================================================================
package regfile_hazard_pkg;

  localparam int AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              v;
    logic [AW_DEF-1:0] rd;
    logic              wen;
    logic              ld;
  } stage_entry_t;

  function automatic logic writes_rd(input stage_entry_t e);
    return e.v & e.wen & (e.rd != '0);
  endfunction

  // Newest producer wins; a matching load in EX is never selected because it stalls.
  function automatic logic [1:0] fwd_select(input logic hit_ex,
                                            input logic ex_is_load,
                                            input logic hit_mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (hit_mem) sel = FWD_WB;
    if (hit_ex && !ex_is_load) sel = FWD_MEM;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_match
// Brief    : Dependency test of one source operand against one in-flight stage
// Revision : 1.0 - initial release
// ============================================================================
module hazard_match
  import regfile_hazard_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          v,
  input  logic          wen,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic          use_rs,
  output logic          hit
);

  // x0 is hard-wired zero, so it can never create a dependency.
  assign hit = v & wen & use_rs & (rd == rs) & (rs != '0);

endmodule
`default_nettype wire

// File: rtl/regfile_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_hazard_ctrl
// Brief    : EX/MEM/WB scoreboard, load-use stall, forwarding and RF write strobe
// Revision : 1.0 - initial release
// ============================================================================
module regfile_hazard_ctrl
  import regfile_hazard_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_ready,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             byp_a,
  output logic             byp_b,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int c_ex  = 0;
  localparam int c_mem = 1;
  localparam int c_wb  = 2;

  stage_entry_t     r_ex;
  stage_entry_t     r_mem;
  stage_entry_t     r_wb;
  logic             r_wb_done;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;

  stage_entry_t       w_id_entry;
  logic [2:0]         w_v;
  logic [2:0]         w_wen;
  logic [2:0][AW-1:0] w_rd;
  logic [1:0][AW-1:0] w_rs;
  logic [1:0]         w_use;
  logic [2:0][1:0]    w_hit;
  logic               w_load_use;
  logic               w_issue;
  logic               w_rf_we;
  logic [1:0]         w_fwd_a_nxt;
  logic [1:0]         w_fwd_b_nxt;
  logic               w_unused;

  assign w_v   = {r_wb.v,   r_mem.v,   r_ex.v};
  assign w_wen = {r_wb.wen, r_mem.wen, r_ex.wen};
  assign w_rd  = {r_wb.rd,  r_mem.rd,  r_ex.rd};
  assign w_rs  = {id_rs2, id_rs1};
  assign w_use = {id_use_rs2, id_use_rs1};

  for (genvar s = 0; s < 3; s++) begin : g_stage
    for (genvar o = 0; o < 2; o++) begin : g_operand
      hazard_match #(
        .AW(AW)
      ) u_match (
        .v      (w_v[s]),
        .wen    (w_wen[s]),
        .rd     (w_rd[s]),
        .rs     (w_rs[o]),
        .use_rs (w_use[o]),
        .hit    (w_hit[s][o])
      );
    end
  end

  assign w_id_entry = '{v: 1'b1, rd: id_rd, wen: id_wen, ld: id_is_load};

  // A taken branch squashes the consumer, so it overrides any load-use stall.
  assign w_load_use = id_valid & (w_hit[c_ex][0] | w_hit[c_ex][1]) & r_ex.ld & ~flush;
  assign w_issue    = id_valid & ~w_load_use & ~flush;

  // done marks a WB write already performed while the pipeline was frozen.
  assign w_rf_we = writes_rd(r_wb) & ~r_wb_done;

  assign w_fwd_a_nxt = fwd_select(w_hit[c_ex][0], r_ex.ld, w_hit[c_mem][0]);
  assign w_fwd_b_nxt = fwd_select(w_hit[c_ex][1], r_ex.ld, w_hit[c_mem][1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_wb_done   <= 1'b0;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_stall_cnt <= '0;
    end else if (mem_ready) begin
      r_wb      <= r_mem;
      r_wb_done <= 1'b0;
      r_mem     <= r_ex;
      if (w_issue) begin
        r_ex    <= w_id_entry;
        r_fwd_a <= w_fwd_a_nxt;
        r_fwd_b <= w_fwd_b_nxt;
      end else begin
        r_ex    <= '0;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end
      if (w_load_use && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end else if (w_rf_we) begin
      r_wb_done <= 1'b1;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall_id  = rst & (w_load_use | ~mem_ready);
  assign bubble_ex = rst & (w_load_use | flush) & mem_ready;
  assign freeze    = rst & ~mem_ready;

  assign byp_a     = w_hit[c_wb][0] & w_rf_we;
  assign byp_b     = w_hit[c_wb][1] & w_rf_we;

  assign rf_we     = w_rf_we;
  assign rf_waddr  = r_wb.rd;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign stall_cnt = r_stall_cnt;

  // The load flag has no meaning once an instruction reaches WB.
  assign w_unused  = r_wb.ld;

endmodule
`default_nettype wire
